// File: rtl/j_mac_acc_pkg.sv
// Shared encodings and constants for the j_mac_acc accumulator slice.
// Optional saturation of res_lo is enabled by defining J_MAC_SAT_EN.
package j_mac_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int EXT_W_DEF = 8;

    localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG = 32'h8000_0000;

endpackage

// File: rtl/j_mac_acc_ext.sv
// Guard-byte updater: extends the 32-bit adder result into the EXT_W guard bits
// and flags signed overflow of the full 32+EXT_W accumulator.
module j_mac_acc_ext #(
    parameter int EXT_W = 8
) (
    input  logic [EXT_W-1:0] base_hi,
    input  logic             prod_sign,
    input  logic             co32,
    output logic [EXT_W-1:0] new_hi,
    output logic             ovf
);

    // Sign-extension of the product plus the carry out of the low word.
    assign new_hi = base_hi + {EXT_W{prod_sign}} + {{(EXT_W-1){1'b0}}, co32};
    assign ovf    = (base_hi[EXT_W-1] == prod_sign) && (new_hi[EXT_W-1] != base_hi[EXT_W-1]);

endmodule

// File: rtl/j_mac_acc.sv
// 40-bit MAC accumulator wrapped around the external 32-bit fast adder.
// Define J_MAC_SAT_EN to clamp res_lo to the 32-bit signed range.
module j_mac_acc
    import j_mac_acc_pkg::*;
#(
    parameter int EXT_W = EXT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             mac_valid,
    output logic             mac_ready,
    input  logic [31:0]      mac_prod,
    input  logic             mac_last,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_c,
    input  logic [31:0]      add_s,
    input  logic             add_co32,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_lo,
    output logic [EXT_W-1:0] res_hi,
    output logic             res_z,
    output logic             res_n,
    output logic             res_c,
    output logic             res_ovf
);

    state_t           state;
    logic [31:0]      acc_lo;
    logic [EXT_W-1:0] acc_hi;
    logic [EXT_W-1:0] base_hi;
    logic [EXT_W-1:0] new_hi;
    logic             step_ovf;
    logic             accept;

    assign mac_ready = (state != DONE);
    assign accept    = mac_valid & mac_ready;

    // A sequence starting from IDLE accumulates from zero without clearing acc first.
    assign add_a   = (state == IDLE) ? 32'd0 : acc_lo;
    assign add_b   = mac_prod;
    assign add_c   = 1'b0;
    assign base_hi = (state == IDLE) ? '0 : acc_hi;

    j_mac_acc_ext #(.EXT_W(EXT_W)) u_ext (
        .base_hi   (base_hi),
        .prod_sign (mac_prod[31]),
        .co32      (add_co32),
        .new_hi    (new_hi),
        .ovf       (step_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state   <= IDLE;
            acc_lo  <= '0;
            acc_hi  <= '0;
            res_c   <= 1'b0;
            res_ovf <= 1'b0;
        end else begin
            if (accept) begin
                acc_lo  <= add_s;
                acc_hi  <= new_hi;
                res_c   <= add_co32;
                res_ovf <= ((state == IDLE) ? 1'b0 : res_ovf) | step_ovf;
            end
            case (state)
                IDLE:    if (accept) state <= mac_last ? DONE : ACC;
                ACC:     if (accept && mac_last) state <= DONE;
                DONE:    if (res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign res_valid = (state == DONE);
    assign res_hi    = acc_hi;
    assign res_n     = acc_hi[EXT_W-1];

`ifdef J_MAC_SAT_EN
    always_comb begin
        res_lo = acc_lo;
        if (acc_hi != {EXT_W{acc_lo[31]}})
            res_lo = acc_hi[EXT_W-1] ? SAT_NEG : SAT_POS;
    end
`else
    assign res_lo = acc_lo;
`endif

    assign res_z = (res_lo == 32'd0);

endmodule

// File: tb/tb_j_mac_acc.sv
// Directed bench for j_mac_acc: behavioural 33-bit adder, 40-bit reference
// accumulator and a result scoreboard queue.
module tb_j_mac_acc;

    logic        clk = 1'b0;
    logic        reset, clear, mac_valid, mac_ready, mac_last;
    logic [31:0] mac_prod, add_a, add_b, add_s;
    logic        add_c, add_co32;
    logic        res_valid, res_ready, res_z, res_n, res_c, res_ovf;
    logic [31:0] res_lo;
    logic [7:0]  res_hi;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] lo;
        logic [7:0]  hi;
        logic        z, n, c, ovf;
    } exp_t;

    exp_t q[$];

    logic [39:0] m_acc;
    logic        m_ovf, m_c;
    bit          m_first = 1'b1;

    always #5 clk = ~clk;

    assign {add_co32, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_c};

    j_mac_acc #(.EXT_W(8)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_prod(mac_prod), .mac_last(mac_last),
        .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_s(add_s), .add_co32(add_co32),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_lo(res_lo), .res_hi(res_hi), .res_z(res_z), .res_n(res_n),
        .res_c(res_c), .res_ovf(res_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model_result();
        exp_t e;
        e.lo = m_acc[31:0];
`ifdef J_MAC_SAT_EN
        if (m_acc[39:32] != {8{m_acc[31]}})
            e.lo = m_acc[39] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        e.hi  = m_acc[39:32];
        e.z   = (e.lo == 32'd0);
        e.n   = m_acc[39];
        e.c   = m_c;
        e.ovf = m_ovf;
        return e;
    endfunction

    // Drive one term; ready is expected high so it is accepted on this edge.
    task automatic send(input logic [31:0] p, input logic last);
        logic [39:0] p40, sum;
        logic [32:0] lo33;
        mac_valid = 1'b1;
        mac_prod  = p;
        mac_last  = last;
        chk("ready_on_send", {63'd0, mac_ready}, 64'd1);
        if (m_first) begin
            m_acc = '0;
            m_ovf = 1'b0;
        end
        p40  = {{8{p[31]}}, p};
        sum  = m_acc + p40;
        lo33 = {1'b0, m_acc[31:0]} + {1'b0, p};
        if (m_acc[39] == p40[39] && sum[39] != m_acc[39]) m_ovf = 1'b1;
        m_c     = lo33[32];
        m_acc   = sum;
        m_first = last;
        if (last) q.push_back(model_result());
        tick();
        mac_valid = 1'b0;
        mac_last  = 1'b0;
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        chk({tag, "_valid"}, {63'd0, res_valid}, 64'd1);
        if (q.size() == 0) begin
            chk({tag, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            e = q.pop_front();
            chk({tag, "_lo"},  {32'd0, res_lo},  {32'd0, e.lo});
            chk({tag, "_hi"},  {56'd0, res_hi},  {56'd0, e.hi});
            chk({tag, "_z"},   {63'd0, res_z},   {63'd0, e.z});
            chk({tag, "_n"},   {63'd0, res_n},   {63'd0, e.n});
            chk({tag, "_c"},   {63'd0, res_c},   {63'd0, e.c});
            chk({tag, "_ovf"}, {63'd0, res_ovf}, {63'd0, e.ovf});
        end
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_lo"},    {32'd0, res_lo},    64'd0);
        chk({tag, "_hi"},    {56'd0, res_hi},    64'd0);
        chk({tag, "_valid"}, {63'd0, res_valid}, 64'd0);
        chk({tag, "_ready"}, {63'd0, mac_ready}, 64'd1);
        chk({tag, "_c"},     {63'd0, res_c},     64'd0);
        chk({tag, "_ovf"},   {63'd0, res_ovf},   64'd0);
        chk({tag, "_z"},     {63'd0, res_z},     64'd1);
        chk({tag, "_n"},     {63'd0, res_n},     64'd0);
    endtask

    initial begin
        logic [31:0] held_lo;
        logic [7:0]  held_hi;
        reset = 1'b1; clear = 1'b0; mac_valid = 1'b0; mac_prod = '0;
        mac_last = 1'b0; res_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check_reset_vals("reset");

        // 1: simple sum with a bubble in the middle
        send(32'd5, 1'b0);
        tick();
        send(32'd7, 1'b0);
        chk("acc_no_valid", {63'd0, res_valid}, 64'd0);
        send(32'd9, 1'b1);
        check_result("sum21");
        chk("sum21_lo_const", {32'd0, res_lo}, 64'd21);
        release_result();

        // 2: -1 + 1 carries out of bit 31 into a zero result
        send(32'hFFFF_FFFF, 1'b0);
        send(32'd1, 1'b1);
        check_result("zero");
        chk("zero_c_const", {63'd0, res_c}, 64'd1);
        release_result();

        // 3: three most-negative products spill into the guard byte
        send(32'h8000_0000, 1'b0);
        send(32'h8000_0000, 1'b0);
        send(32'h8000_0000, 1'b1);
        check_result("neg3");
        chk("neg3_hi_const", {56'd0, res_hi}, 64'hFE);
        release_result();

        // 4: two most-positive products exceed the 32-bit range
        send(32'h7FFF_FFFF, 1'b0);
        send(32'h7FFF_FFFF, 1'b1);
        check_result("pos2");
        release_result();

        // 40-bit overflow: 257 * (2^31-1) wraps past 2^39-1
        for (int i = 0; i < 257; i++) send(32'h7FFF_FFFF, i == 256);
        check_result("ovf40");
        chk("ovf40_const", {63'd0, res_ovf}, 64'd1);
        release_result();

        // ovf clears at the start of the next sequence
        send(32'd4, 1'b1);
        check_result("ovf_clr");
        release_result();

        // 5: back-pressure in DONE
        send(32'd100, 1'b1);
        check_result("hold");
        held_lo = res_lo;
        held_hi = res_hi;
        mac_valid = 1'b1;
        mac_prod  = 32'd123;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_ready", {63'd0, mac_ready}, 64'd0);
            chk("hold_valid", {63'd0, res_valid}, 64'd1);
            chk("hold_lo",    {32'd0, res_lo},    {32'd0, held_lo});
            chk("hold_hi",    {56'd0, res_hi},    {56'd0, held_hi});
        end
        mac_valid = 1'b0;
        release_result();
        chk("idle_valid", {63'd0, res_valid}, 64'd0);
        chk("idle_ready", {63'd0, mac_ready}, 64'd1);
        chk("idle_keep",  {32'd0, res_lo},    64'd100);
        send(32'd11, 1'b1);
        check_result("restart");
        release_result();

        // 6: clear mid-sequence drops the concurrent term
        send(32'd100, 1'b0);
        send(32'd200, 1'b0);
        clear = 1'b1; mac_valid = 1'b1; mac_prod = 32'd50; mac_last = 1'b1;
        tick();
        clear = 1'b0; mac_valid = 1'b0; mac_last = 1'b0;
        m_first = 1'b1;
        check_reset_vals("clear");
        send(32'd3, 1'b1);
        check_result("post_clear");

        // reset while in DONE
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_vals("reset_done");

        chk("queue_drained", {32'd0, q.size()}, 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/j_mac_acc.md
Name: j_mac_acc

Overview:
- 40-bit multiply-accumulate accumulator for the Jerry DSP datapath. It sits directly upstream and downstream of the 32-bit fast adder: it drives the adder's a, b and carry-in, then registers the sum and co32 back into the accumulator.
- Signed 32-bit products arrive from the multiplier through a valid/ready handshake.
- The accumulated result goes to the register-file writeback with flags.
- The upper 8 extension bits (guard byte) are maintained locally from co32 and the product sign.

Parameters:
- EXT_W, 8, width of the accumulator guard extension (accumulator is 32+EXT_W bits).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous abort; zeroes the accumulator and returns to IDLE
- mac_valid  in  1  product term valid
- mac_ready  out  1  term accepted when mac_valid & mac_ready
- mac_prod  in  32  signed product term, bit 0 = LSB
- mac_last  in  1  final term of the sequence (qualified by accept)
- add_a  out  32  adder operand a (combinational)
- add_b  out  32  adder operand b (combinational)
- add_c  out  1  adder carry-in (combinational)
- add_s  in  32  adder sum
- add_co32  in  1  adder carry out of bit 31
- res_valid  out  1  result available
- res_ready  in  1  writeback consumes the result
- res_lo  out  32  accumulator bits 31:0 (saturated if the option is enabled)
- res_hi  out  EXT_W  accumulator guard bits
- res_z  out  1  res_lo == 0
- res_n  out  1  accumulator sign (res_hi MSB)
- res_c  out  1  co32 of the last accumulate
- res_ovf  out  1  sticky: 40-bit signed overflow occurred in this sequence

Behaviour:
- States are IDLE, ACC and DONE. Reset goes to IDLE, with acc_lo=0, acc_hi=0, res_c=0, res_ovf=0, res_valid=0.
- mac_ready is 1 in IDLE and ACC, and 0 in DONE.
- Adder drive:
  - add_a = (state==IDLE) ? 0 : acc_lo
  - add_b = mac_prod
  - add_c = 0
  - add_a and add_b are driven every cycle; they are used only on accept.
- On accept:
  - acc_lo <= add_s.
  - acc_hi <= base_hi + {EXT_W{mac_prod[31]}} + add_co32, modulo 2^EXT_W. base_hi is 0 in IDLE and acc_hi otherwise.
  - res_c <= add_co32.
  - res_ovf sets if base_hi and the product sign-extension have equal MSBs and the new acc_hi MSB differs. In IDLE, res_ovf is first cleared and then this is evaluated.
- Transitions:
  - IDLE: accept & !mac_last -> ACC; accept & mac_last -> DONE.
  - ACC: accept & mac_last -> DONE; otherwise stay.
  - DONE: res_ready -> IDLE.
- Latency: a term accepted at cycle N is reflected in acc and res_* at cycle N+1. res_valid = (state==DONE).
- res_* hold stable while in DONE.
- After DONE -> IDLE, res_lo, res_hi and the flags keep their values until the next accept. The first accept in IDLE overwrites them; acc is not cleared on leaving DONE.
- Priority: reset > clear > handshake. clear in any state zeroes acc and flags, sets state=IDLE, and drops a term presented in the same cycle.
- Wrap-around: acc_hi wraps silently; only res_ovf records it.
- No accept occurs when mac_valid is 0; there are no bubbles penalties.
- res_z and res_n are combinational from the registered acc.

Optional Feature:
- Macro: J_MAC_SAT_EN.
- When defined:
  - If the 40-bit acc is outside the 32-bit signed range (acc_hi is not all copies of acc_lo[31]), res_lo = acc_hi MSB ? 32'h8000_0000 : 32'h7FFF_FFFF.
  - res_z is computed on the saturated value.
  - acc itself is never modified.
- When undefined: res_lo = acc_lo, unmodified truncation.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=2'd0, ACC=2'd1, DONE=2'd2)
  - EXT_W default
  - saturation constants SAT_POS / SAT_NEG
- Natural sub-module: j_mac_ext, the guard-byte updater. Inputs: base_hi, prod sign, co32. Outputs: new hi and overflow bit. Purely combinational.
- The FSM and registers live in the top level.

Test Plan:
1. Reset, then accept prods 5, 7, 9 with last on 9 → res_valid at the next cycle, res_lo=21, res_hi=0, z=0, n=0, ovf=0.
2. Accept prods 32'hFFFF_FFFF (−1), then 1 with last → res_lo=0, res_hi=0, res_c=1, res_z=1.
3. Accept 32'h8000_0000 ×3, last on the third → res_hi=8'hFE, res_lo=32'h8000_0000, res_n=1. With J_MAC_SAT_EN → res_lo=32'h8000_0000 (saturated negative).
4. Accept 32'h7FFF_FFFF ×2 with last → res_hi=0, res_lo=32'hFFFF_FFFE. With J_MAC_SAT_EN → res_lo=32'h7FFF_FFFF.
5. Hold res_ready=0 for 4 cycles in DONE with mac_valid=1 → mac_ready=0, outputs stable. Then raise res_ready → IDLE next cycle, and a new term starts from zero.
6. Assert clear together with mac_valid in the middle of ACC → term dropped, acc=0, state IDLE. A reset pulse during DONE → all outputs return to reset values on the next cycle.
